// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the long-latency register scoreboard.
// Holds the register-address type and the per-register net-delta encoding.
package reg_scoreboard_pkg;

  localparam int NREG      = 32;
  localparam int CNT_W_DEF = 2;
  localparam int TOT_W_DEF = 4;

  typedef logic [4:0] reg_addr_t;

  // Net change on one register in one cycle; range is -2..+1.
  typedef enum logic [1:0] {
    DELTA_NONE = 2'd0,
    DELTA_INC  = 2'd1,
    DELTA_DEC1 = 2'd2,
    DELTA_DEC2 = 2'd3
  } delta_e;

  function automatic delta_e delta_of(input logic inc, input logic dec_a, input logic dec_b);
    delta_e d;
    case ({inc, dec_a, dec_b})
      3'b100:                d = DELTA_INC;
      3'b010, 3'b001, 3'b111: d = DELTA_DEC1;
      3'b011:                d = DELTA_DEC2;
      default:               d = DELTA_NONE;
    endcase
    return d;
  endfunction

  // Requested decrement size, before clamping at zero.
  function automatic logic [1:0] delta_mag(input delta_e d);
    logic [1:0] m;
    case (d)
      DELTA_DEC1: m = 2'd1;
      DELTA_DEC2: m = 2'd2;
      default:    m = 2'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill bundle between the pipeline control and the scoreboard.
// master = pipeline side, slave = scoreboard side.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_rs1_used;
  logic      id_rs2_used;
  reg_addr_t id_rd;
  logic      id_long_wen;
  logic      id_issue;
  logic      wb_valid;
  reg_addr_t wb_rd;
  logic      kill_valid;
  reg_addr_t kill_rd;

  logic      stall;
  logic      rs1_hazard;
  logic      rs2_hazard;
  logic      waw_full;
  logic      idle;
  logic      overflow_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_long_wen, id_issue, wb_valid, wb_rd, kill_valid, kill_rd,
    input  stall, rs1_hazard, rs2_hazard, waw_full, idle, overflow_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_long_wen, id_issue, wb_valid, wb_rd, kill_valid, kill_rd,
    output stall, rs1_hazard, rs2_hazard, waw_full, idle, overflow_err
  );

endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's in-flight writer counter. Applies the combined net delta and
// clamps at zero, flagging underflow when a decrement exceeds the count.
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  delta_e           delta;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    delta      = delta_of(inc, dec_a, dec_b);
    count_next = count;
    underflow  = 1'b0;
    case (delta)
      DELTA_INC:  count_next = count + CNT_W'(1);
      DELTA_DEC1: begin
        if (count == '0) underflow = 1'b1;
        else             count_next = count - CNT_W'(1);
      end
      DELTA_DEC2: begin
        if (count <= CNT_W'(1)) begin
          count_next = '0;
          underflow  = 1'b1;
        end else begin
          count_next = count - CNT_W'(2);
        end
      end
      default: ;
    endcase
  end

  // NOTE: these counters are architectural state, so unlike a RAM they are reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    // NOTE: sequential state uses non-blocking assignment only.
    else        count <= count_next;
  end

  assign nonzero = (count != '0);
  assign full    = (count == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency writers; raises decode stalls.
// Optional REG_SCOREBOARD_WB_BYPASS_EN: same-cycle writeback releases RAW hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave sb
);

  logic             issue_inc;
  logic [NREG-1:1]  inc_v;
  logic [NREG-1:1]  wb_v;
  logic [NREG-1:1]  kill_v;
  logic [NREG-1:1]  under_v;
  logic [NREG-1:0]  nz_v;
  logic [NREG-1:0]  full_v;
  logic [CNT_W-1:0] cnt_a [NREG];

  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] total_next;
  logic [TOT_W-1:0] tot_up;
  logic [TOT_W-1:0] tot_dn;
  logic             idle_q;
  logic             ovf_q;

  logic rs1_raw;
  logic rs2_raw;
  logic rs1_rel;
  logic rs2_rel;
  logic waw;

  assign issue_inc = sb.id_issue && sb.id_long_wen && (sb.id_rd != '0);

  // x0 has no counter: it always reads as empty and never saturates.
  assign cnt_a[0]  = '0;
  assign nz_v[0]   = 1'b0;
  assign full_v[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    assign inc_v[i]  = issue_inc     && (sb.id_rd   == reg_addr_t'(i));
    assign wb_v[i]   = sb.wb_valid   && (sb.wb_rd   == reg_addr_t'(i));
    assign kill_v[i] = sb.kill_valid && (sb.kill_rd == reg_addr_t'(i));

    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_v[i]),
      .dec_a     (wb_v[i]),
      .dec_b     (kill_v[i]),
      .count     (cnt_a[i]),
      .nonzero   (nz_v[i]),
      .full      (full_v[i]),
      .underflow (under_v[i])
    );
  end

  // Total follows the clamped per-register changes so it stays equal to the sum of counts.
  always_comb begin
    tot_up = '0;
    tot_dn = '0;
    for (int i = 1; i < NREG; i++) begin
      if (delta_of(inc_v[i], wb_v[i], kill_v[i]) == DELTA_INC) begin
        tot_up = tot_up + TOT_W'(1);
      end else if (under_v[i]) begin
        tot_dn = tot_dn + TOT_W'(cnt_a[i]);
      end else begin
        tot_dn = tot_dn + TOT_W'(delta_mag(delta_of(inc_v[i], wb_v[i], kill_v[i])));
      end
    end
    total_next = total_q + tot_up - tot_dn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      idle_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      total_q <= total_next;
      idle_q  <= (total_next == '0);
      ovf_q   <= ovf_q | (|under_v);
    end
  end

  always_comb begin
    rs1_raw = sb.id_valid && sb.id_rs1_used && nz_v[sb.id_rs1];
    rs2_raw = sb.id_valid && sb.id_rs2_used && nz_v[sb.id_rs2];
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    // The last outstanding writer retiring now is picked up by WB forwarding.
    rs1_rel = sb.wb_valid && (sb.wb_rd == sb.id_rs1) && (cnt_a[sb.id_rs1] == CNT_W'(1));
    rs2_rel = sb.wb_valid && (sb.wb_rd == sb.id_rs2) && (cnt_a[sb.id_rs2] == CNT_W'(1));
`else
    rs1_rel = 1'b0;
    rs2_rel = 1'b0;
`endif
    waw = sb.id_valid && sb.id_long_wen && full_v[sb.id_rd];
  end

  assign sb.rs1_hazard   = rs1_raw && !rs1_rel;
  assign sb.rs2_hazard   = rs2_raw && !rs2_rel;
  assign sb.waw_full     = waw;
  assign sb.stall        = sb.rs1_hazard || sb.rs2_hazard || waw;
  assign sb.idle         = idle_q;
  assign sb.overflow_err = ovf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard (default CNT_W=2) plus
// hand-written reset sequences.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.CNT_W(2), .TOT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       lw;
    logic       iss;
    logic       wbv;
    logic [4:0] wbrd;
    logic       kv;
    logic [4:0] krd;
    logic       e_h1;
    logic       e_h2;
    logic       e_waw;
    logic       e_idle;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(
    input logic vld, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
    input logic u2, input logic [4:0] rd, input logic lw, input logic iss,
    input logic wbv, input logic [4:0] wbrd, input logic kv, input logic [4:0] krd,
    input logic h1, input logic h2, input logic waw, input logic idl, input logic ovf);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.lw = lw; v.iss = iss; v.wbv = wbv; v.wbrd = wbrd; v.kv = kv; v.krd = krd;
    v.e_h1 = h1; v.e_h2 = h2; v.e_waw = waw; v.e_idle = idl; v.e_ovf = ovf;
    return v;
  endfunction

  task automatic check(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.id_valid    = v.vld;
    sb_if.id_rs1      = v.rs1;
    sb_if.id_rs1_used = v.u1;
    sb_if.id_rs2      = v.rs2;
    sb_if.id_rs2_used = v.u2;
    sb_if.id_rd       = v.rd;
    sb_if.id_long_wen = v.lw;
    sb_if.id_issue    = v.iss;
    sb_if.wb_valid    = v.wbv;
    sb_if.wb_rd       = v.wbrd;
    sb_if.kill_valid  = v.kv;
    sb_if.kill_rd     = v.krd;
  endtask

  task automatic check_all(input string tag, input logic h1, input logic h2,
                           input logic waw, input logic idl, input logic ovf);
    check({tag, " rs1_hazard"},   sb_if.rs1_hazard,   h1);
    check({tag, " rs2_hazard"},   sb_if.rs2_hazard,   h2);
    check({tag, " waw_full"},     sb_if.waw_full,     waw);
    check({tag, " stall"},        sb_if.stall,        h1 | h2 | waw);
    check({tag, " idle"},         sb_if.idle,         idl);
    check({tag, " overflow_err"}, sb_if.overflow_err, ovf);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Expectations are the outputs seen during that row's cycle, before its clock edge.
    //            vld rs1 u1 rs2 u2 rd lw iss  wbv wbrd kv krd   h1  h2 waw idle ovf
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 5, 1, 1,   0, 0, 0, 0,   0,   0, 0, 1, 0); // load x5
    vecs[2]  = mk(1, 5, 1, 0, 0, 6, 0, 0,   0, 0, 0, 0,   1,   0, 0, 0, 0); // use x5
    vecs[3]  = mk(1, 5, 1, 0, 0, 6, 0, 0,   1, 5, 0, 0,   !BYP, 0, 0, 0, 0); // wb x5
    vecs[4]  = mk(1, 5, 1, 0, 0, 6, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 7, 1, 1,   0, 0, 0, 0,   0,   0, 0, 1, 0); // x7 #1
    vecs[6]  = mk(1, 0, 0, 0, 0, 7, 1, 1,   0, 0, 0, 0,   0,   0, 0, 0, 0); // x7 #2
    vecs[7]  = mk(1, 0, 0, 0, 0, 7, 1, 1,   0, 0, 0, 0,   0,   0, 0, 0, 0); // x7 #3
    vecs[8]  = mk(1, 0, 0, 7, 1, 7, 1, 0,   0, 0, 0, 0,   0,   1, 1, 0, 0); // cnt7=max
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 7, 0, 0,   0,   0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 7, 1, 7,   0,   0, 0, 0, 0); // wb+kill x7
    vecs[11] = mk(1, 7, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 9, 1, 1,   0, 0, 0, 0,   0,   0, 0, 1, 0); // load x9
    vecs[13] = mk(1, 0, 0, 0, 0, 9, 1, 1,   1, 9, 0, 0,   0,   0, 0, 0, 0); // issue+wb x9
    vecs[14] = mk(1, 9, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0,   1,   0, 0, 0, 0); // cnt9 still 1
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 9, 0, 0,   0,   0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0);
    vecs[17] = mk(1, 0, 0, 0, 0, 3, 1, 1,   0, 0, 0, 0,   0,   0, 0, 1, 0); // x3 #1
    vecs[18] = mk(1, 0, 0, 0, 0, 3, 1, 1,   0, 0, 0, 0,   0,   0, 0, 0, 0); // x3 #2
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 3, 1, 3,   0,   0, 0, 0, 0); // wb+kill x3
    vecs[20] = mk(1, 3, 1, 3, 1, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0);
    vecs[21] = mk(1, 0, 1, 0, 1, 0, 1, 1,   0, 0, 0, 0,   0,   0, 0, 1, 0); // x0 issue
    vecs[22] = mk(1, 0, 1, 0, 1, 0, 1, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 4, 0, 0,   0,   0, 0, 1, 0); // wb x4 @0
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 1);
    vecs[25] = mk(1, 4, 1, 4, 1, 4, 1, 0,   0, 0, 0, 0,   0,   0, 0, 1, 1);

    // Reset with a decode reading x5 present: outputs must all be at reset values.
    rst_n = 1'b0;
    drive(mk(1, 5, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(vecs[0]);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].e_h1, vecs[i].e_h2, vecs[i].e_waw,
                vecs[i].e_idle, vecs[i].e_ovf);
    end

    // Mid-stream asynchronous reset with writers outstanding and the error set.
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_all("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
